// File: rtl/vmem_arbiter.sv
`default_nettype none
// vmem_arbiter: shares one single-port memory between the HPS and CORES requesters.
// HPS has priority, bounded by a starvation counter; cores are served round-robin. Rev 1.0
module vmem_arbiter #(
  parameter int WIDTH      = 32,
  parameter int ADDR_W     = 17,
  parameter int CORES      = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [ADDR_W-1:0]         hps_address,
  input  logic                      hps_write,
  input  logic                      hps_read,
  input  logic [WIDTH-1:0]          hps_data_in,
  output logic                      hps_waitrequest,
  output logic [WIDTH-1:0]          hps_data_out,
  output logic                      hps_readdatavalid,
  input  logic [CORES-1:0]          core_req,
  input  logic [CORES-1:0]          core_we,
  input  logic [CORES*ADDR_W-1:0]   core_addr,
  input  logic [CORES*WIDTH-1:0]    core_wdata,
  output logic [CORES-1:0]          core_gnt,
  output logic [CORES-1:0]          core_rvalid,
  output logic [WIDTH-1:0]          core_rdata,
  output logic [ADDR_W-1:0]         mem_address,
  output logic [WIDTH-1:0]          mem_data,
  output logic                      mem_wren,
  input  logic [WIDTH-1:0]          mem_q
);

  localparam int CW = (CORES > 1) ? $clog2(CORES) : 1;
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  logic [CW-1:0] rr_ptr;
  logic [CW-1:0] core_sel;
  logic [SW-1:0] starve_cnt;
  logic          rd_valid;
  logic          rd_hps;
  logic [CW-1:0] rd_core;

  logic hps_pend;
  logic any_core;
  logic core_win;
  logic hps_win;
  logic acc_we;
  int   idx;

  // Scan from farthest to nearest so the first requester after rr_ptr is the last one kept.
  always_comb begin
    core_sel = rr_ptr;
    idx      = 0;
    for (int k = CORES; k >= 1; k--) begin
      idx = (int'(rr_ptr) + k) % CORES;
      if (core_req[idx]) core_sel = CW'(idx);
    end
  end

  assign hps_pend = hps_read | hps_write;
  assign any_core = |core_req;
  assign core_win = reset_n && any_core && (!hps_pend || (starve_cnt == STARVE_LIM));
  assign hps_win  = reset_n && hps_pend && !core_win;
  assign acc_we   = hps_win ? hps_write : core_we[core_sel];

  assign hps_waitrequest = !reset_n || (hps_pend && !hps_win);
  assign core_gnt        = core_win ? (CORES'(1) << core_sel) : '0;
  assign mem_wren        = (hps_win || core_win) && acc_we;
  assign mem_address     = hps_win ? hps_address : core_addr[core_sel*ADDR_W +: ADDR_W];
  assign mem_data        = hps_win ? hps_data_in : core_wdata[core_sel*WIDTH +: WIDTH];

  assign core_rvalid       = (rd_valid && !rd_hps) ? (CORES'(1) << rd_core) : '0;
  assign hps_readdatavalid = rd_valid && rd_hps;
  assign core_rdata        = mem_q;
  assign hps_data_out      = mem_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr     <= CW'(CORES - 1);
      starve_cnt <= '0;
      rd_valid   <= 1'b0;
      rd_hps     <= 1'b0;
      rd_core    <= '0;
    end else begin
      rd_valid <= (hps_win || core_win) && !acc_we;
      rd_hps   <= hps_win;
      rd_core  <= core_sel;
      if (core_win) rr_ptr <= core_sel;
      if (core_win || !any_core) starve_cnt <= '0;
      else if (hps_win && (starve_cnt != STARVE_LIM)) starve_cnt <= starve_cnt + SW'(1);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vmem_arbiter.sv
`default_nettype none
// tb_vmem_arbiter: directed and random checks of vmem_arbiter against a rule-level model.
// Rev 1.0
module tb_vmem_arbiter;

  localparam int WIDTH      = 32;
  localparam int ADDR_W     = 17;
  localparam int CORES      = 4;
  localparam int STARVE_MAX = 8;
  localparam int DEPTH      = 1 << ADDR_W;

  logic                    clk = 1'b0;
  logic                    reset_n;
  logic [ADDR_W-1:0]       hps_address;
  logic                    hps_write, hps_read;
  logic [WIDTH-1:0]        hps_data_in;
  logic                    hps_waitrequest;
  logic [WIDTH-1:0]        hps_data_out;
  logic                    hps_readdatavalid;
  logic [CORES-1:0]        core_req, core_we;
  logic [CORES*ADDR_W-1:0] core_addr;
  logic [CORES*WIDTH-1:0]  core_wdata;
  logic [CORES-1:0]        core_gnt, core_rvalid;
  logic [WIDTH-1:0]        core_rdata;
  logic [ADDR_W-1:0]       mem_address;
  logic [WIDTH-1:0]        mem_data;
  logic                    mem_wren;
  logic [WIDTH-1:0]        mem_q;

  vmem_arbiter #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .CORES(CORES), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .reset_n(reset_n),
    .hps_address(hps_address), .hps_write(hps_write), .hps_read(hps_read),
    .hps_data_in(hps_data_in), .hps_waitrequest(hps_waitrequest),
    .hps_data_out(hps_data_out), .hps_readdatavalid(hps_readdatavalid),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_gnt(core_gnt), .core_rvalid(core_rvalid), .core_rdata(core_rdata),
    .mem_address(mem_address), .mem_data(mem_data), .mem_wren(mem_wren), .mem_q(mem_q)
  );

  always #5 clk = ~clk;

  // Single-port memory with one-cycle read latency.
  logic [WIDTH-1:0] bmem [0:DEPTH-1];
  always @(posedge clk) begin
    if (mem_wren) bmem[mem_address] <= mem_data;
    mem_q <= bmem[mem_address];
  end

  // Reference model state: memory image, pointer, starvation count, read owner one cycle ago.
  logic [WIDTH-1:0] model_mem [0:DEPTH-1];
  int m_rr, m_starve, m_owner;
  logic [WIDTH-1:0] m_rdata;
  int vecs = 0;
  int fails = 0;

  bit e_cwin, e_hwin, e_acc, e_we, e_anyc;
  int e_core;
  logic [ADDR_W-1:0] e_addr;
  logic [WIDTH-1:0]  e_data;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_rr = CORES - 1;
    m_starve = 0;
    m_owner = -1;
  endtask

  function automatic logic [ADDR_W-1:0] pool(input int i);
    return (i < 8) ? ADDR_W'(i) : ADDR_W'(65536 + i - 8);
  endfunction

  task automatic set_core(input int c, input bit req, input bit we,
                          input logic [ADDR_W-1:0] a, input logic [WIDTH-1:0] d);
    core_req[c] = req;
    core_we[c]  = we;
    core_addr[c*ADDR_W +: ADDR_W] = a;
    core_wdata[c*WIDTH +: WIDTH]  = d;
  endtask

  task automatic idle();
    hps_write = 0; hps_read = 0; hps_address = '0; hps_data_in = '0;
    core_req = '0; core_we = '0; core_addr = '0; core_wdata = '0;
  endtask

  // Evaluate the arbitration rules for the current inputs and compare all outputs.
  task automatic settle();
    bit hp;
    logic [CORES-1:0] e_gnt, e_rv;
    @(negedge clk);
    hp      = hps_read || hps_write;
    e_anyc  = (core_req != '0);
    e_cwin  = reset_n && e_anyc && (!hp || m_starve == STARVE_MAX);
    e_hwin  = reset_n && hp && !e_cwin;
    e_acc   = e_cwin || e_hwin;
    e_core  = -1;
    if (e_cwin)
      for (int k = 1; k <= CORES; k++) begin
        int c;
        c = (m_rr + k) % CORES;
        if (core_req[c] && e_core < 0) e_core = c;
      end
    e_gnt = (e_core >= 0) ? (CORES'(1) << e_core) : '0;
    if (e_hwin) begin
      e_we = hps_write; e_addr = hps_address; e_data = hps_data_in;
    end else if (e_core >= 0) begin
      e_we = core_we[e_core];
      e_addr = core_addr[e_core*ADDR_W +: ADDR_W];
      e_data = core_wdata[e_core*WIDTH +: WIDTH];
    end else begin
      e_we = 0; e_addr = '0; e_data = '0;
    end
    e_rv = (m_owner >= 0 && m_owner < CORES) ? (CORES'(1) << m_owner) : '0;
    chk("core_gnt", 64'(core_gnt), 64'(e_gnt));
    chk("hps_waitrequest", 64'(hps_waitrequest), 64'(!reset_n || (hp && !e_hwin)));
    chk("mem_wren", 64'(mem_wren), 64'(e_acc && e_we));
    chk("core_rvalid", 64'(core_rvalid), 64'(e_rv));
    chk("hps_readdatavalid", 64'(hps_readdatavalid), 64'(m_owner == CORES));
    if (e_acc) chk("mem_address", 64'(mem_address), 64'(e_addr));
    if (e_acc && e_we) chk("mem_data", 64'(mem_data), 64'(e_data));
    if (m_owner >= 0 && m_owner < CORES) chk("core_rdata", 64'(core_rdata), 64'(m_rdata));
    if (m_owner == CORES) chk("hps_data_out", 64'(hps_data_out), 64'(m_rdata));
  endtask

  task automatic advance();
    @(posedge clk);
    if (!reset_n) model_reset();
    else begin
      m_owner = -1;
      if (e_acc && e_we) model_mem[e_addr] = e_data;
      else if (e_acc) begin
        m_owner = e_hwin ? CORES : e_core;
        m_rdata = model_mem[e_addr];
      end
      if (e_cwin || !e_anyc) m_starve = 0;
      else if (e_hwin && m_starve < STARVE_MAX) m_starve++;
      if (e_cwin) m_rr = e_core;
    end
    #1;
  endtask

  initial begin
    logic [CORES-1:0] seq [0:4];
    seq[0] = 4'b0001; seq[1] = 4'b0010; seq[2] = 4'b0100; seq[3] = 4'b1000; seq[4] = 4'b0001;

    // Reset with every input active.
    reset_n = 0;
    hps_write = 1; hps_read = 1; hps_address = '0; hps_data_in = '1;
    core_req = '1; core_we = '1; core_addr = '0; core_wdata = '1;
    model_reset();
    settle();
    chk("rst_gnt", 64'(core_gnt), 0);
    chk("rst_rvalid", 64'({core_rvalid, hps_readdatavalid}), 0);
    chk("rst_wren", 64'(mem_wren), 0);
    chk("rst_waitreq", 64'(hps_waitrequest), 1);
    advance();
    reset_n = 1;

    // Round-robin rotation from reset, all cores writing.
    idle();
    for (int c = 0; c < CORES; c++) set_core(c, 1, 1, ADDR_W'(c), WIDTH'(32'h100 + c));
    for (int i = 0; i < 5; i++) begin
      settle();
      chk("rr_seq", 64'(core_gnt), 64'(seq[i]));
      advance();
    end
    idle(); settle(); advance();

    // HPS program-space write beats a waiting core.
    hps_write = 1; hps_address = ADDR_W'(65536); hps_data_in = 32'h214C62A4;
    set_core(1, 1, 0, ADDR_W'(7), '0);
    settle();
    chk("hps_win_wait", 64'(hps_waitrequest), 0);
    chk("hps_win_wren", 64'(mem_wren), 1);
    chk("hps_win_addr", 64'(mem_address), 65536);
    chk("hps_win_gnt", 64'(core_gnt), 0);
    advance();
    idle(); settle(); advance();

    // HPS writes 6 to address 5, core 3 reads it back.
    hps_write = 1; hps_address = ADDR_W'(5); hps_data_in = 32'd6;
    settle(); advance();
    idle();
    set_core(3, 1, 0, ADDR_W'(5), '0);
    settle(); advance();
    idle();
    settle();
    chk("c3_rvalid", 64'(core_rvalid), 64'(4'b1000));
    chk("c3_rdata", 64'(core_rdata), 6);
    advance();
    idle(); settle(); advance();

    // Starvation bound: continuous HPS reads against core 2.
    hps_read = 1; hps_address = ADDR_W'(5);
    set_core(2, 1, 0, ADDR_W'(65536), '0);
    for (int i = 1; i <= 10; i++) begin
      settle();
      chk("starve_waitreq", 64'(hps_waitrequest), 64'(i == 9));
      chk("starve_gnt2", 64'(core_gnt[2]), 64'(i == 9));
      advance();
    end
    idle(); settle(); advance();

    // Read in flight killed by a reset pulse between edges.
    set_core(0, 1, 0, ADDR_W'(65536), '0);
    settle(); advance();
    idle();
    reset_n = 0;
    #1;
    chk("pulse_rvalid_in_rst", 64'(core_rvalid), 0);
    reset_n = 1;
    model_reset();
    settle();
    chk("pulse_no_rvalid0", 64'(core_rvalid[0]), 0);
    advance();

    // Preload the random address pool through the HPS.
    for (int i = 0; i < 16; i++) begin
      idle();
      hps_write = 1; hps_address = pool(i); hps_data_in = $urandom;
      settle(); advance();
    end

    // Random mix of HPS and core traffic.
    for (int n = 0; n < 400; n++) begin
      idle();
      hps_write   = ($urandom_range(0, 3) == 0);
      hps_read    = ($urandom_range(0, 2) == 0);
      hps_address = pool($urandom_range(0, 15));
      hps_data_in = $urandom;
      for (int c = 0; c < CORES; c++)
        set_core(c, $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0,
                 pool($urandom_range(0, 15)), $urandom);
      settle(); advance();
    end
    idle(); settle(); advance();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vmem_arbiter.md
VMEM_ARBITER -- requirements
Module: vmem_arbiter

Interface
REQ-001 Parameter WIDTH, default 32, data word width.
REQ-002 Parameter ADDR_W, default 17, word address width; addresses 0..65535 are data, 65536 and up are program.
REQ-003 Parameter CORES, default 4, number of core requesters.
REQ-004 Parameter STARVE_MAX, default 8, maximum consecutive HPS grants while any core waits.
REQ-005 clk  in  1  single clock; all state changes on rising edge.
REQ-006 reset_n  in  1  asynchronous, active-low reset.
REQ-007 hps_address  in  ADDR_W  HPS word address.
REQ-008 hps_write / hps_read  in  1 each  HPS access strobes.
REQ-009 hps_data_in  in  WIDTH  HPS write data.
REQ-010 hps_waitrequest  out  1  HPS access not accepted this cycle.
REQ-011 hps_data_out  out  WIDTH  HPS read data.
REQ-012 hps_readdatavalid  out  1  hps_data_out valid.
REQ-013 core_req / core_we  in  CORES each  per-core request and write flag.
REQ-014 core_addr  in  CORES*ADDR_W  packed core addresses; core i at bits [i*ADDR_W +: ADDR_W].
REQ-015 core_wdata  in  CORES*WIDTH  packed core write data.
REQ-016 core_gnt  out  CORES  one-hot acceptance.
REQ-017 core_rvalid  out  CORES  one-hot read-data-valid.
REQ-018 core_rdata  out  WIDTH  shared read data bus.
REQ-019 mem_address  out  ADDR_W, mem_data  out  WIDTH, mem_wren  out  1  port to single-port memory.
REQ-020 mem_q  in  WIDTH  memory read data, valid exactly 1 cycle after the address is presented.

Function
REQ-021 The block SHALL accept at most one access per cycle; an access is accepted in the cycle its grant (core_gnt bit, or hps_waitrequest=0) is high.
REQ-022 Grant selection and the mem_* outputs SHALL be combinational from the current inputs and registered state; with no accepted access, mem_wren=0.
REQ-023 HPS pending (hps_read|hps_write) SHALL win unless starve_cnt==STARVE_MAX and any core_req is high; in that case the round-robin core wins.
REQ-024 hps_waitrequest SHALL be 1 when HPS is pending and not selected, else 0.
REQ-025 hps_write and hps_read both high SHALL be treated as a write only.
REQ-026 Core selection SHALL be round-robin: first requesting core searching from rr_ptr+1 modulo CORES.
REQ-027 rr_ptr SHALL update to the granted core index only on a core grant.
REQ-028 starve_cnt SHALL increment (saturating at STARVE_MAX) on an HPS grant while any core_req is high, and clear to 0 on any core grant or when no core requests.
REQ-029 An accepted write SHALL drive mem_wren=1 with the winner's address and data in the same cycle; it produces no rvalid.
REQ-030 An accepted read SHALL register the owner; next cycle the owner's rvalid (core_rvalid bit or hps_readdatavalid) SHALL pulse for one cycle with data = mem_q.
REQ-031 core_rdata and hps_data_out SHALL both drive mem_q; only the valid strobes are owner-specific.
REQ-032 Back-to-back reads SHALL sustain one per cycle with rvalids in acceptance order.

Reset
REQ-033 While reset_n=0: rr_ptr=CORES-1, starve_cnt=0, owner cleared, core_gnt=0, core_rvalid=0, hps_readdatavalid=0, mem_wren=0, hps_waitrequest=1.
REQ-034 A read accepted in the cycle before reset assertion SHALL NOT produce an rvalid after reset release.
REQ-035 After reset release, the first contended core grant SHALL go to core 0.

Verification
REQ-036 Reset: reset_n=0 with all inputs active -> all gnt/valid outputs 0, mem_wren 0, hps_waitrequest 1.
REQ-037 core_req=4'b1111 held, no HPS -> core_gnt 0001,0010,0100,1000,0001 on consecutive cycles.
REQ-038 HPS write addr 65536 data 0x214C62A4 while core_req[1]=1 -> hps_waitrequest 0, mem_wren 1, mem_address 65536, core_gnt 0000.
REQ-039 HPS reads held continuously plus core_req[2]=1 -> 8 HPS grants, then in the 9th cycle core_gnt[2]=1 and hps_waitrequest=1; HPS wins again in the 10th cycle.
REQ-040 HPS writes 6 to addr 5; then core 3 reads addr 5 -> next cycle core_rvalid=4'b1000, core_rdata=6, other rvalids 0.
REQ-041 Core 0 read accepted, reset_n pulsed low before the next edge -> no core_rvalid[0] pulse after release.
